// File: rtl/pixel_frame_writer_if.sv
// pixel_frame_writer_if: pixel stream in, frame buffer write port and status out
// Ports (signals):
//   data_in_r/g/b, height, width, data_ready   pixel stream from the parser
//   wr_en, wr_addr, wr_data                     frame buffer write port
//   busy, frame_done, size_err                  status to the display side
//   frame_count                                 only when FRAME_CNT_EN is defined
// Modports: master = parser/bench side, slave = pixel_frame_writer.
interface pixel_frame_writer_if #(
  parameter int ADDR_W = 15,
  parameter int COLOR_BITS = 4
);
  logic [7:0] data_in_r;
  logic [7:0] data_in_g;
  logic [7:0] data_in_b;
  logic [7:0] height;
  logic [7:0] width;
  logic data_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3*COLOR_BITS-1:0] wr_data;
  logic busy;
  logic frame_done;
  logic size_err;
`ifdef FRAME_CNT_EN
  logic [7:0] frame_count;
`endif
  modport master (
    output data_in_r, data_in_g, data_in_b, height, width, data_ready,
    input wr_en, wr_addr, wr_data, busy, frame_done, size_err
`ifdef FRAME_CNT_EN
    , input frame_count
`endif
  );
  modport slave (
    input data_in_r, data_in_g, data_in_b, height, width, data_ready,
    output wr_en, wr_addr, wr_data, busy, frame_done, size_err
`ifdef FRAME_CNT_EN
    , output frame_count
`endif
  );
endinterface

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: packs parser RGB pixels to 4:4:4 and writes them to the frame buffer in raster order
// Ports:
//   clk    system clock (parser domain)
//   reset  synchronous, active-low
//   bus    pixel_frame_writer_if.slave: pixel stream in, write port and status out
// Optional: FRAME_CNT_EN adds bus.frame_count, a wrapping count of completed frames.
module pixel_frame_writer #(
  parameter int ADDR_W = 15,
  parameter int COLOR_BITS = 4
) (
  input logic clk,
  input logic reset,
  pixel_frame_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] w_q, h_q, row, col, w_n, h_n, row_n, col_n;
  logic [ADDR_W-1:0] addr_q, addr_n, wr_addr_n;
  logic [3*COLOR_BITS-1:0] pix, wr_data_n;
  logic wr_en_n, busy_n, done_n, err_n;
  logic [15:0] prod;
  logic [16:0] cap;
  logic bad, last_col, last;
  assign pix = {bus.data_in_r[7-:COLOR_BITS], bus.data_in_g[7-:COLOR_BITS], bus.data_in_b[7-:COLOR_BITS]};
  assign prod = 16'(bus.width) * 16'(bus.height);
  // one extra bit so a full 2^16-pixel buffer still compares correctly
  assign cap = 17'(1) << ADDR_W;
  assign bad = bus.width == 8'd0 || bus.height == 8'd0 || {1'b0, prod} > cap;
  assign last_col = col == w_q - 8'd1;
  assign last = last_col && row == h_q - 8'd1;
  always_comb begin
    state_n = state;
    w_n = w_q;
    h_n = h_q;
    row_n = row;
    col_n = col;
    addr_n = addr_q;
    wr_en_n = 1'b0;
    wr_addr_n = bus.wr_addr;
    wr_data_n = bus.wr_data;
    busy_n = bus.busy;
    done_n = 1'b0;
    err_n = bus.size_err;
    unique case (state)
      IDLE: if (bus.data_ready) begin
        w_n = bus.width;
        h_n = bus.height;
        if (bad) err_n = 1'b1;
        else begin
          wr_en_n = 1'b1;
          wr_addr_n = '0;
          wr_data_n = pix;
          addr_n = ADDR_W'(1);
          busy_n = 1'b1;
          // a single-column frame wraps to the next row right after pixel 0
          col_n = bus.width == 8'd1 ? 8'd0 : 8'd1;
          row_n = bus.width == 8'd1 ? 8'd1 : 8'd0;
          state_n = prod == 16'd1 ? DONE : WRITE;
        end
      end
      WRITE: if (bus.data_ready) begin
        wr_en_n = 1'b1;
        wr_addr_n = addr_q;
        wr_data_n = pix;
        addr_n = addr_q + ADDR_W'(1);
        col_n = last_col ? 8'd0 : col + 8'd1;
        row_n = last_col ? row + 8'd1 : row;
        state_n = last ? DONE : WRITE;
      end
      DONE: begin
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      w_q <= '0;
      h_q <= '0;
      row <= '0;
      col <= '0;
      addr_q <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.size_err <= 1'b0;
    end else begin
      state <= state_n;
      w_q <= w_n;
      h_q <= h_n;
      row <= row_n;
      col <= col_n;
      addr_q <= addr_n;
      bus.wr_en <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
      bus.busy <= busy_n;
      bus.frame_done <= done_n;
      bus.size_err <= err_n;
    end
  end
`ifdef FRAME_CNT_EN
  // advances on the same edge that raises frame_done
  always_ff @(posedge clk) begin
    if (!reset) bus.frame_count <= '0;
    else if (state == DONE) bus.frame_count <= bus.frame_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: table vectors, directed corner sequences and random frames against a reference model
module tb_pixel_frame_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dr = 1'b0;
  logic [7:0] w_in = '0, h_in = '0, r_in = '0, g_in = '0, b_in = '0;
  bit sel = 1'b0;
  int pass_cnt = 0, total_cnt = 0;
  bit err_m[2];
  int cnt_m[2];
  logic [31:0] act0[$], act1[$];
  int done0 = 0, done1 = 0;

  always #5 clk = ~clk;

  pixel_frame_writer_if #(.ADDR_W(15), .COLOR_BITS(4)) b0 ();
  pixel_frame_writer_if #(.ADDR_W(8), .COLOR_BITS(4)) b8 ();

  assign b0.data_in_r = r_in;
  assign b0.data_in_g = g_in;
  assign b0.data_in_b = b_in;
  assign b0.width = w_in;
  assign b0.height = h_in;
  assign b0.data_ready = dr & ~sel;
  assign b8.data_in_r = r_in;
  assign b8.data_in_g = g_in;
  assign b8.data_in_b = b_in;
  assign b8.width = w_in;
  assign b8.height = h_in;
  assign b8.data_ready = dr & sel;

  pixel_frame_writer #(.ADDR_W(15), .COLOR_BITS(4)) dut (.clk(clk), .reset(rst_n), .bus(b0));
  pixel_frame_writer #(.ADDR_W(8), .COLOR_BITS(4)) dut8 (.clk(clk), .reset(rst_n), .bus(b8));

  always @(negedge clk) begin
    if (b0.wr_en === 1'b1) act0.push_back(32'({b0.wr_addr, b0.wr_data}));
    if (b8.wr_en === 1'b1) act1.push_back(32'({b8.wr_addr, b8.wr_data}));
    if (b0.frame_done === 1'b1) done0++;
    if (b8.frame_done === 1'b1) done1++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [11:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return 12'((int'(r) / 16) * 256 + (int'(g) / 16) * 16 + int'(b) / 16);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    dr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    err_m[0] = 0;
    err_m[1] = 0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
  endtask

  // Reference: a valid header yields w*h writes at addresses 0..w*h-1 holding the
  // channel MSBs, each visible the cycle after its strobe, and one frame_done pulse.
  task automatic run_frame(input bit s, input int w, input int h, input int gmin, input int gmax, input bit fixed);
    logic [11:0] exp_q[$];
    logic [7:0] r, g, b;
    logic [31:0] a;
    bit valid;
    int n, gaps, na;
    valid = w != 0 && h != 0 && w * h <= (s ? 256 : 32768);
    n = valid ? w * h : 1;
    sel = s;
    act0 = {};
    act1 = {};
    done0 = 0;
    done1 = 0;
    for (int k = 0; k < n; k++) begin
      r = fixed ? 8'h12 : 8'($urandom);
      g = fixed ? 8'h34 : 8'($urandom);
      b = fixed ? 8'h56 : 8'($urandom);
      dr = 1'b1;
      w_in = k == 0 ? 8'(w) : 8'($urandom);
      h_in = k == 0 ? 8'(h) : 8'($urandom);
      r_in = r;
      g_in = g;
      b_in = b;
      if (valid) exp_q.push_back(pack(r, g, b));
      tick();
      dr = 1'b0;
      chk("wr_en_after_strobe", 32'(s ? b8.wr_en : b0.wr_en), 32'(valid));
      gaps = $urandom_range(gmax, gmin);
      for (int j = 0; j < gaps; j++) begin
        tick();
        chk("wr_en_in_gap", 32'(s ? b8.wr_en : b0.wr_en), 0);
      end
    end
    for (int t = 0; t < 8 && (s ? done1 : done0) == 0; t++) tick();
    tick();
    na = s ? act1.size() : act0.size();
    chk("write_count", 32'(na), 32'(exp_q.size()));
    for (int i = 0; i < na && i < exp_q.size(); i++) begin
      a = s ? act1[i] : act0[i];
      chk("write_addr", a >> 12, 32'(i));
      chk("write_data", 32'(a[11:0]), 32'(exp_q[i]));
    end
    chk("frame_done_pulses", 32'(s ? done1 : done0), 32'(valid));
    if (!valid) err_m[s] = 1;
    else cnt_m[s] = (cnt_m[s] + 1) % 256;
    chk("size_err", 32'(s ? b8.size_err : b0.size_err), 32'(err_m[s]));
    chk("busy_idle", 32'(s ? b8.busy : b0.busy), 0);
`ifdef FRAME_CNT_EN
    chk("frame_count", 32'(s ? b8.frame_count : b0.frame_count), 32'(cnt_m[s]));
`endif
  endtask

  typedef struct {
    logic rst, dr;
    logic [7:0] w, h, r, g, b;
    logic en;
    logic [14:0] addr;
    logic [11:0] data;
    logic busy, done, err;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic d, input logic [7:0] w, input logic [7:0] h,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic en,
                              input logic [14:0] addr, input logic [11:0] data, input logic busy,
                              input logic done, input logic err);
    vec_t v;
    v.rst = rst; v.dr = d; v.w = w; v.h = h; v.r = r; v.g = g; v.b = b;
    v.en = en; v.addr = addr; v.data = data; v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  initial begin
    vec_t tv[17];
    int rw, rh;
    bit rs;
    tv[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    tv[1] = mk(0, 1, 4, 2, 8'hF0, 8'hF0, 8'hF0, 0, 0, 12'h000, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      tv[2 + k] = mk(1, 1, k == 0 ? 8'd4 : 8'd9, k == 0 ? 8'd2 : 8'd9, 8'hF0, 8'hF0, 8'hF0, 1, 15'(k), 12'hFFF, 1, 0, 0);
    tv[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 12'hFFF, 0, 1, 0);
    tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 12'hFFF, 0, 0, 0);
    tv[12] = mk(1, 1, 0, 5, 8'hAA, 8'hBB, 8'hCC, 0, 7, 12'hFFF, 0, 0, 1);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 12'hFFF, 0, 0, 1);
    tv[14] = mk(1, 1, 1, 1, 8'h12, 8'h34, 8'h56, 1, 0, 12'h135, 1, 0, 1);
    tv[15] = mk(1, 1, 4, 2, 8'h12, 8'h34, 8'h56, 0, 0, 12'h135, 0, 1, 1);
    tv[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 12'h135, 0, 0, 1);
    sel = 1'b0;
    tick();
    foreach (tv[i]) begin
      rst_n = tv[i].rst;
      dr = tv[i].dr;
      w_in = tv[i].w;
      h_in = tv[i].h;
      r_in = tv[i].r;
      g_in = tv[i].g;
      b_in = tv[i].b;
      tick();
      chk($sformatf("vec%0d_wr_en", i), 32'(b0.wr_en), 32'(tv[i].en));
      chk($sformatf("vec%0d_wr_addr", i), 32'(b0.wr_addr), 32'(tv[i].addr));
      chk($sformatf("vec%0d_wr_data", i), 32'(b0.wr_data), 32'(tv[i].data));
      chk($sformatf("vec%0d_busy", i), 32'(b0.busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d_frame_done", i), 32'(b0.frame_done), 32'(tv[i].done));
      chk($sformatf("vec%0d_size_err", i), 32'(b0.size_err), 32'(tv[i].err));
    end
    err_m[0] = 1;
    err_m[1] = 0;
    cnt_m[0] = 2;
    cnt_m[1] = 0;
    dr = 1'b0;
    run_frame(0, 3, 3, 1, 5, 1);
    run_frame(1, 17, 16, 0, 1, 0);
    run_frame(1, 16, 16, 0, 0, 0);
    chk("last_addr_256", act1.size() == 256 ? act1[255] >> 12 : 32'hFFFF_FFFF, 255);
    sel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dr = 1'b1;
      w_in = 8'd4;
      h_in = 8'd2;
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("rst_mid_wr_en", 32'(b0.wr_en), 0);
    chk("rst_mid_wr_addr", 32'(b0.wr_addr), 0);
    chk("rst_mid_wr_data", 32'(b0.wr_data), 0);
    chk("rst_mid_busy", 32'(b0.busy), 0);
    chk("rst_mid_frame_done", 32'(b0.frame_done), 0);
    chk("rst_mid_size_err", 32'(b0.size_err), 0);
    rst_n = 1'b1;
    dr = 1'b0;
    tick();
    chk("post_rst_wr_en", 32'(b0.wr_en), 0);
    err_m[0] = 0;
    err_m[1] = 0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    run_frame(0, 2, 1, 0, 1, 0);
    for (int it = 0; it < 20; it++) begin
      rs = 1'($urandom);
      rw = rs ? $urandom_range(20, 1) : $urandom_range(12, 0);
      rh = rs ? $urandom_range(20, 1) : $urandom_range(12, 0);
      run_frame(rs, rw, rh, 0, 2, 0);
    end
`ifdef FRAME_CNT_EN
    do_reset();
    for (int f = 0; f < 257; f++) run_frame(0, 1, 1, 0, 0, 0);
    chk("frame_count_wrap", 32'(b0.frame_count), 1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
- Downstream of the UART packet parser; consumes its per-pixel RGB bytes, the height/width header fields and the data_ready strobe.
- Packs each pixel to 4:4:4 RGB and writes it into the display frame buffer RAM, raster order, at a computed linear address.
- Tracks row/column position and reports frame completion and size errors to the display side.

Parameters:
- ADDR_W, 15, frame buffer address width; capacity is 2^ADDR_W pixels.
- COLOR_BITS, 4, bits kept per channel (MSBs of each 8-bit byte); wr_data width is 3*COLOR_BITS.

Ports:
- clk  in  1  system clock; the parser clock domain.
- reset  in  1  synchronous, active-low reset.
- data_in_r  in  8  red byte from parser.
- data_in_g  in  8  green byte from parser.
- data_in_b  in  8  blue byte from parser.
- height  in  8  frame height in rows; valid when the first pixel's data_ready is high.
- width  in  8  frame width in columns; valid when the first pixel's data_ready is high.
- data_ready  in  1  one-cycle strobe per valid pixel.
- wr_en  out  1  frame buffer write enable.
- wr_addr  out  ADDR_W  frame buffer write address.
- wr_data  out  3*COLOR_BITS  packed {R,G,B} MSBs.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is written.
- size_err  out  1  sticky; the frame header is invalid.

Behaviour:
- Reset (reset==0 at a clk edge): all of the following are cleared to 0: wr_en, wr_addr, wr_data, busy, frame_done, size_err, row, col and latched dimensions. State goes to IDLE. Reset overrides any event in the same cycle. A frame interrupted by reset is abandoned with no further writes.
- FSM states: IDLE, WRITE, DONE.
- IDLE, data_ready=1:
  - Latch width and height into w_q and h_q.
  - If w_q or h_q is 0, or w_q*h_q > 2^ADDR_W (computed at 16 bits): set size_err, do not write, stay in IDLE.
  - Otherwise write pixel 0 at address 0, set col=1, row=0, busy=1, and go to WRITE.
  - Special case: a 1x1 frame goes straight to DONE.
- WRITE, data_ready=1:
  - Write the pixel at the current address.
  - Update position: if col==w_q-1, set col=0 and row=row+1; otherwise col=col+1.
  - The address increments by exactly 1 per pixel and equals row*w_q+col. Implement it as an incremental counter, not a multiplier.
  - If this is pixel (h_q-1, w_q-1), go to DONE.
- WRITE, data_ready=0: hold all state.
- DONE (one cycle): frame_done=1, busy=0, return to IDLE. A data_ready arriving in DONE is dropped.
- Write latency: wr_en, wr_addr and wr_data are registered and valid the cycle after data_ready. wr_en is high for exactly one cycle per accepted pixel.
- Back-to-back strobes (data_ready every cycle) are accepted with no bubbles.
- Pixel packing: wr_data = {r[7:8-COLOR_BITS], g[7:8-COLOR_BITS], b[7:8-COLOR_BITS]}.
- size_err is cleared only by reset. A later valid header still starts a new frame while size_err stays high.
- height and width are ignored outside the first pixel of a frame.

Optional Feature:
- Macro: FRAME_CNT_EN.
- Defined: adds output frame_count[7:0], reset to 0. It increments in the same cycle frame_done is high and wraps 255 to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then w=4, h=2, 8 pixels back-to-back with r=g=b=0xF0 -> wr_en high for 8 consecutive cycles starting one cycle after the first strobe. wr_addr runs 0..7, wr_data=0xFFF. frame_done pulses the cycle after the last write; busy is high throughout.
- w=3, h=3, strobes spaced 1-5 idle cycles apart, r=0x12 g=0x34 b=0x56 -> 9 writes at addresses 0..8, wr_data=0x135 each, no writes in the gap cycles.
- w=0, h=5 header -> no wr_en, size_err=1, state stays IDLE. Then a valid 1x1 frame -> single write at address 0, frame_done pulses, size_err still 1.
- With ADDR_W=8: w=17, h=16 (272>256) -> size_err=1, no writes. Then w=16, h=16 -> 256 writes ending at address 255.
- Reset asserted after 5 of 8 pixels of a 4x2 frame -> outputs cleared the next edge. A new 2x1 frame then writes addresses 0 and 1.
- FRAME_CNT_EN defined: 257 consecutive 1x1 frames -> frame_count reads 1 after the final frame_done (wrapped).
